// File: rtl/spu_preload_sequencer_if.sv
// spu_preload_sequencer_if: host word stream plus the three SPU preload ports and status.
// master = the sequencer, slave = host/core side.
interface spu_preload_sequencer_if #(
  parameter int IMEM_AW = 10,
  parameter int RF_AW   = 7,
  parameter int LS_AW   = 15
);
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic               load_en;
  logic [31:0]        instruction_in;
  logic [IMEM_AW-1:0] instr_load_addr;
  logic               preload_en;
  logic [RF_AW-1:0]   preload_addr;
  logic [127:0]       preload_values;
  logic               preload_LS_en;
  logic [LS_AW-1:0]   preload_LS_addr;
  logic [127:0]       preload_LS_data;
  logic               core_hold;
  logic               busy;
  logic               err;
  modport master (
    input  in_valid, in_data,
    output in_ready, load_en, instruction_in, instr_load_addr,
           preload_en, preload_addr, preload_values,
           preload_LS_en, preload_LS_addr, preload_LS_data,
           core_hold, busy, err
  );
  modport slave (
    output in_valid, in_data,
    input  in_ready, load_en, instruction_in, instr_load_addr,
           preload_en, preload_addr, preload_values,
           preload_LS_en, preload_LS_addr, preload_LS_data,
           core_hold, busy, err
  );
endinterface

// File: rtl/spu_preload_sequencer.sv
// spu_preload_sequencer: decodes header-framed host records into SPU IMEM/RF/LS preload writes.
// Optional SPU_PRELOAD_CHECKSUM_EN: XOR checksum word verified after START before releasing the core.
module spu_preload_sequencer #(
  parameter int IMEM_AW      = 10,
  parameter int RF_AW        = 7,
  parameter int LS_AW        = 15,
  parameter int LS_ADDR_STEP = 1
) (
  input logic clk,
  input logic rst,
  spu_preload_sequencer_if.master bus
);
  localparam int AW = 15;
  typedef enum logic [2:0] {HDR, IMEM, RF, LS, RUN, CHK} state_t;
  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [14:0]        cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [95:0]        asm_q, asm_d;
  logic               err_q, err_d;
  logic               load_en_q, load_en_d, pre_en_q, pre_en_d, ls_en_q, ls_en_d;
  logic [31:0]        instr_q, instr_d;
  logic [IMEM_AW-1:0] iaddr_q, iaddr_d;
  logic [RF_AW-1:0]   pre_addr_q, pre_addr_d;
  logic [127:0]       pre_val_q, pre_val_d;
  logic [LS_AW-1:0]   ls_addr_q, ls_addr_d;
  logic [127:0]       ls_data_q, ls_data_d;
  logic [31:0]        word;
  logic [127:0]       asm_nx;
  logic               in_ready, acc, last;
  logic [1:0]         tgt;
`ifdef SPU_PRELOAD_CHECKSUM_EN
  logic [31:0]        csum_q, csum_d;
`endif
  assign word     = bus.in_data;
  assign tgt      = word[31:30];
  assign asm_nx   = {asm_q, word};
  assign in_ready = state_q != RUN;
  assign acc      = bus.in_valid & in_ready;
  assign last     = state_q == IMEM || idx_q == 2'd3;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    err_d      = err_q;
    load_en_d  = 1'b0;
    pre_en_d   = 1'b0;
    ls_en_d    = 1'b0;
    instr_d    = instr_q;
    iaddr_d    = iaddr_q;
    pre_addr_d = pre_addr_q;
    pre_val_d  = pre_val_q;
    ls_addr_d  = ls_addr_q;
    ls_data_d  = ls_data_q;
`ifdef SPU_PRELOAD_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (acc) begin
      case (state_q)
        HDR: begin
          if (tgt == 2'd3) begin
            err_d = err_q | (|word[29:0]);
`ifdef SPU_PRELOAD_CHECKSUM_EN
            state_d = |word[29:0] ? HDR : CHK;
`else
            state_d = |word[29:0] ? HDR : RUN;
`endif
          end else if (|word[14:0]) begin
            addr_d  = word[29:15];
            cnt_d   = word[14:0];
            idx_d   = 2'd0;
            state_d = tgt == 2'd0 ? IMEM : tgt == 2'd1 ? RF : LS;
          end
        end
        IMEM, RF, LS: begin
          asm_d = asm_nx[95:0];
          idx_d = idx_q + 2'd1;
`ifdef SPU_PRELOAD_CHECKSUM_EN
          csum_d = csum_q ^ word;
`endif
          if (last) begin
            load_en_d  = state_q == IMEM;
            pre_en_d   = state_q == RF;
            ls_en_d    = state_q == LS;
            instr_d    = state_q == IMEM ? word : instr_q;
            iaddr_d    = state_q == IMEM ? addr_q[IMEM_AW-1:0] : iaddr_q;
            pre_addr_d = state_q == RF ? addr_q[RF_AW-1:0] : pre_addr_q;
            pre_val_d  = state_q == RF ? asm_nx : pre_val_q;
            ls_addr_d  = state_q == LS ? addr_q[LS_AW-1:0] : ls_addr_q;
            ls_data_d  = state_q == LS ? asm_nx : ls_data_q;
            addr_d     = addr_q + (state_q == LS ? AW'(LS_ADDR_STEP) : AW'(1));
            cnt_d      = cnt_q - 15'd1;
            state_d    = cnt_q == 15'd1 ? HDR : state_q;
          end
        end
`ifdef SPU_PRELOAD_CHECKSUM_EN
        CHK: begin
          state_d = word == csum_q ? RUN : HDR;
          err_d   = err_q | (word != csum_q);
          csum_d  = word == csum_q ? csum_q : 32'd0;
        end
`endif
        default: ;
      endcase
    end
  end
  // Address outputs keep only the target's width, so the shared counter wraps per target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HDR;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
      load_en_q  <= 1'b0;
      pre_en_q   <= 1'b0;
      ls_en_q    <= 1'b0;
      instr_q    <= '0;
      iaddr_q    <= '0;
      pre_addr_q <= '0;
      pre_val_q  <= '0;
      ls_addr_q  <= '0;
      ls_data_q  <= '0;
`ifdef SPU_PRELOAD_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
      load_en_q  <= load_en_d;
      pre_en_q   <= pre_en_d;
      ls_en_q    <= ls_en_d;
      instr_q    <= instr_d;
      iaddr_q    <= iaddr_d;
      pre_addr_q <= pre_addr_d;
      pre_val_q  <= pre_val_d;
      ls_addr_q  <= ls_addr_d;
      ls_data_q  <= ls_data_d;
`ifdef SPU_PRELOAD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end
  assign bus.in_ready        = in_ready;
  assign bus.load_en         = load_en_q;
  assign bus.instruction_in  = instr_q;
  assign bus.instr_load_addr = iaddr_q;
  assign bus.preload_en      = pre_en_q;
  assign bus.preload_addr    = pre_addr_q;
  assign bus.preload_values  = pre_val_q;
  assign bus.preload_LS_en   = ls_en_q;
  assign bus.preload_LS_addr = ls_addr_q;
  assign bus.preload_LS_data = ls_data_q;
  assign bus.core_hold       = state_q != RUN;
  assign bus.busy            = state_q == IMEM || state_q == RF || state_q == LS;
  assign bus.err             = err_q;
endmodule

// File: tb/tb_spu_preload_sequencer.sv
// tb_spu_preload_sequencer: random record streams checked against a record-level write model.
module tb_spu_preload_sequencer;
  localparam int IMEM_AW = 10, RF_AW = 7, LS_AW = 15, LS_ADDR_STEP = 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  spu_preload_sequencer_if #(.IMEM_AW(IMEM_AW), .RF_AW(RF_AW), .LS_AW(LS_AW)) bus ();
  spu_preload_sequencer #(.IMEM_AW(IMEM_AW), .RF_AW(RF_AW), .LS_AW(LS_AW), .LS_ADDR_STEP(LS_ADDR_STEP))
    dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int kind; int addr; logic [127:0] data;} wr_t;
  wr_t exp_q[$];
  wr_t got_q[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_csum = '0;
  logic fin_strobe;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void push_wr(input bit to_got, input int k, input int a, input logic [127:0] d);
    wr_t w;
    w.kind = k;
    w.addr = a;
    w.data = d;
    if (to_got) got_q.push_back(w);
    else exp_q.push_back(w);
  endfunction
  function automatic logic [31:0] hdr(input int t, input int a, input int n);
    return {t[1:0], a[14:0], n[14:0]};
  endfunction
  // Reference: walk each record, emit one write per item at base + k*step modulo the target size.
  function automatic void model(input logic [31:0] ws[$]);
    int i = 0;
    while (i < ws.size()) begin
      int t, a, n;
      t = int'(ws[i][31:30]);
      a = int'(ws[i][29:15]);
      n = int'(ws[i][14:0]);
      i++;
      if (t == 3) continue;
      for (int k = 0; k < n; k++) begin
        if (t == 0) begin
          push_wr(0, 0, (a + k) % (1 << IMEM_AW), 128'(ws[i]));
          m_csum ^= ws[i];
          i++;
        end else begin
          m_csum ^= ws[i] ^ ws[i+1] ^ ws[i+2] ^ ws[i+3];
          push_wr(0, t, t == 1 ? (a + k) % (1 << RF_AW) : (a + k * LS_ADDR_STEP) % (1 << LS_AW),
                  {ws[i], ws[i+1], ws[i+2], ws[i+3]});
          i += 4;
        end
      end
    end
  endfunction
  always @(negedge clk) begin
    if (bus.load_en) push_wr(1, 0, int'(bus.instr_load_addr), 128'(bus.instruction_in));
    if (bus.preload_en) push_wr(1, 1, int'(bus.preload_addr), bus.preload_values);
    if (bus.preload_LS_en) push_wr(1, 2, int'(bus.preload_LS_addr), bus.preload_LS_data);
    if (bus.load_en | bus.preload_en | bus.preload_LS_en)
      check("strobe_onehot", 128'($countones({bus.load_en, bus.preload_en, bus.preload_LS_en})), 128'(1));
    if (!bus.core_hold)
      check("run_quiet", 128'({bus.load_en, bus.preload_en, bus.preload_LS_en, bus.busy, bus.in_ready}), 128'(0));
  end
  task automatic send_word(input logic [31:0] w, input int idle);
    repeat (idle) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int t = 0; t < 20 && !bus.in_ready; t++) @(negedge clk);
    if (!bus.in_ready) begin
      check("ready_timeout", 128'(bus.in_ready), 128'(1));
      bus.in_valid = 1'b0;
    end else @(posedge clk);
  endtask
  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      wr_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_kind"}, 128'(g.kind), 128'(e.kind));
      check({tag, "_addr"}, 128'(g.addr), 128'(e.addr));
      check({tag, "_data"}, g.data, e.data);
    end
    got_q.delete();
    exp_q.delete();
  endtask
  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic run_words(input string tag, input logic [31:0] ws[$], input int mode);
    model(ws);
    foreach (ws[i]) send_word(ws[i], mode == 0 ? 0 : mode == 1 ? int'(i > 0) : int'($urandom_range(0, 2)));
    @(negedge clk);
    bus.in_valid = 1'b0;
    fin_strobe = bus.load_en | bus.preload_en | bus.preload_LS_en;
    check({tag, "_hdr_ret"}, 128'({bus.busy, bus.in_ready}), 128'(2'b01));
    repeat (2) @(negedge clk);
    compare_writes(tag);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 128'({bus.load_en, bus.preload_en, bus.preload_LS_en}), 128'(0));
    check({tag, "_addrs"}, 128'({bus.instr_load_addr, bus.preload_addr, bus.preload_LS_addr}), 128'(0));
    check({tag, "_data"}, bus.preload_values | bus.preload_LS_data | 128'(bus.instruction_in), 128'(0));
    check({tag, "_status"}, 128'({bus.core_hold, bus.busy, bus.err, bus.in_ready}), 128'(4'b1001));
  endtask
  initial begin
    logic [31:0] ws[$];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    run_words("imem", '{hdr(0, 0, 3), 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003}, 0);
    check("imem_fin_strobe", 128'(fin_strobe), 128'(1));
    run_words("rf", '{hdr(1, 5, 1), 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}, 0);
    check("rf_fin_strobe", 128'(fin_strobe), 128'(1));
    run_words("wrap", '{hdr(0, 1023, 2), 32'hDEAD_0001, 32'hDEAD_0002}, 1);
    run_words("cnt0", '{hdr(1, 3, 0), hdr(0, 7, 1), 32'h0BAD_F00D}, 0);
    run_words("ls", '{hdr(2, 32'h7FFF, 2), 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8}, 2);
    for (int r = 0; r < 25; r++) begin
      ws.delete();
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        int t, n;
        t = int'($urandom_range(0, 2));
        n = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 3));
        ws.push_back(hdr(t, int'($urandom_range(0, 32767)), n));
        repeat (n * (t == 0 ? 1 : 4)) ws.push_back($urandom);
      end
      run_words("rand", ws, int'($urandom_range(0, 2)) == 1 ? 1 : 2 * int'($urandom_range(0, 1)));
    end
    send_word(32'hC000_0001, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bad_start", 128'({bus.err, bus.core_hold, bus.in_ready, bus.busy}), 128'(4'b1110));
    run_words("after_err", '{hdr(0, 9, 1), 32'h5555_AAAA}, 0);
    send_word(hdr(1, 9, 1), 0);
    send_word(32'hFEED_0001, 0);
    send_word(32'hFEED_0002, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_busy", 128'(bus.busy), 128'(1));
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    m_csum = '0;
    got_q.delete();
    run_words("fresh_rf", '{hdr(1, 12, 1), 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004}, 2);
`ifdef SPU_PRELOAD_CHECKSUM_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_csum = '0;
    run_words("ck1", '{hdr(0, 0, 1), 32'h0000_00FF}, 0);
    send_word(32'hC000_0000, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("chk_wait", 128'({bus.core_hold, bus.in_ready, bus.busy}), 128'(3'b110));
    send_word(m_csum ^ 32'h1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("chk_bad", 128'({bus.err, bus.core_hold, bus.in_ready}), 128'(3'b111));
    m_csum = '0;
    run_words("ck2", '{hdr(0, 0, 1), 32'h0000_00FF}, 0);
    send_word(32'hC000_0000, 0);
    send_word(m_csum, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("chk_good", 128'({bus.core_hold, bus.in_ready}), 128'(0));
`else
    send_word(32'hC000_0000, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("start", 128'({bus.core_hold, bus.in_ready, bus.err, bus.busy}), 128'(0));
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = i[0] ? hdr(0, 0, 1) : $urandom;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("run_nowr", 128'(got_q.size()), 128'(0));
    check("run_hold", 128'(bus.core_hold), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
